// File: rtl/afifo_word_packer.sv
// Packs bytes popped from an async FIFO read port into LANES-wide words with per-lane enables.
// Latency: a word is presented the cycle after its last byte (or flush/timeout) is taken.
// Backpressure: while a word waits for word_ready, no byte is popped, so the afifo fills up.
module afifo_word_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                          rclk,
  input  logic                          r_nrst,
  input  logic                          empty,
  input  logic [DATA_WIDTH-1:0]         rdata,
  output logic                          rinc,
  input  logic                          flush,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic [DATA_WIDTH*LANES-1:0]   word_data,
  output logic [LANES-1:0]              byte_en,
  output logic [15:0]                   word_cnt
);

  // lane_cnt must be able to hold LANES (the value after the last lane is filled).
  localparam int LW = $clog2(LANES + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                        state, state_nxt;
  logic [LW-1:0]                 lane_cnt, lane_cnt_nxt;
  logic [IW-1:0]                 idle_cnt, idle_cnt_nxt;
  logic [DATA_WIDTH*LANES-1:0]   data_nxt;
  logic [LANES-1:0]              be_nxt;
  logic [15:0]                   cnt_nxt;

  logic handshake;
  logic timeout_hit;
  logic flush_eff;

  // Pop strobe: free-running in FILL, only alongside a handshake in HOLD; silenced during reset.
  always_comb begin
    rinc        = r_nrst & ~empty & ((state == FILL) | ((state == HOLD) & word_ready));
    word_valid  = (state == HOLD);
    handshake   = (state == HOLD) & word_ready;
    timeout_hit = (state == FILL) && (lane_cnt != '0) && (idle_cnt == IW'(TIMEOUT - 1));
    flush_eff   = flush | timeout_hit;
  end

  // Next-state and datapath update for the FILL/HOLD machine.
  always_comb begin
    state_nxt    = state;
    lane_cnt_nxt = lane_cnt;
    data_nxt     = word_data;
    be_nxt       = byte_en;
    cnt_nxt      = word_cnt;
    case (state)
      FILL: begin
        if (rinc) begin
          for (int i = 0; i < LANES; i++) begin
            if (lane_cnt == LW'(i)) begin
              data_nxt[i*DATA_WIDTH +: DATA_WIDTH] = rdata;
              be_nxt[i] = 1'b1;
            end
          end
          lane_cnt_nxt = lane_cnt + LW'(1);
        end
        // A same-cycle byte rides along with a flush; an empty flush is dropped.
        if ((rinc && (lane_cnt == LW'(LANES - 1))) ||
            (flush_eff && ((lane_cnt != '0) || rinc))) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (handshake) begin
          state_nxt    = FILL;
          cnt_nxt      = word_cnt + 16'd1;
          data_nxt     = '0;
          be_nxt       = '0;
          lane_cnt_nxt = '0;
          // The next word starts in the handshake cycle so a steady stream has no bubbles.
          if (rinc) begin
            data_nxt[DATA_WIDTH-1:0] = rdata;
            be_nxt                   = LANES'(1);
            lane_cnt_nxt             = LW'(1);
          end
        end
      end
      default: state_nxt = FILL;
    endcase

    // Idle timer only runs while a partial word sits in FILL without new bytes.
    if (rinc || (state == HOLD) || (lane_cnt == '0) || timeout_hit) begin
      idle_cnt_nxt = '0;
    end else begin
      idle_cnt_nxt = idle_cnt + IW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge rclk or negedge r_nrst) begin
    if (!r_nrst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers; reset discards any partial word.
  always_ff @(posedge rclk or negedge r_nrst) begin
    if (!r_nrst) begin
      lane_cnt  <= '0;
      idle_cnt  <= '0;
      word_data <= '0;
      byte_en   <= '0;
      word_cnt  <= '0;
    end else begin
      lane_cnt  <= lane_cnt_nxt;
      idle_cnt  <= idle_cnt_nxt;
      word_data <= data_nxt;
      byte_en   <= be_nxt;
      word_cnt  <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_afifo_word_packer.sv
// Directed bench for afifo_word_packer with a queue standing in for the afifo read side.
// Latency: checks are cycle-exact against hand-computed expectations.
// Backpressure: word_ready is driven directly by the stimulus.
module tb_afifo_word_packer;

  logic        rclk;
  logic        r_nrst;
  logic        empty;
  logic [7:0]  rdata;
  logic        rinc;
  logic        flush;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic [3:0]  byte_en;
  logic [15:0] word_cnt;

  afifo_word_packer #(
    .DATA_WIDTH (8),
    .LANES      (4),
    .TIMEOUT    (16)
  ) dut (
    .rclk       (rclk),
    .r_nrst     (r_nrst),
    .empty      (empty),
    .rdata      (rdata),
    .rinc       (rinc),
    .flush      (flush),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .byte_en    (byte_en),
    .word_cnt   (word_cnt)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_pop_empty = 0;
  int wv_cycles = 0;
  int run_cur = 0;
  int run_max = 0;
  int rinc_total = 0;
  int bad_rinc = 0;
  int bad_stab = 0;

  logic [7:0]  src[$];
  logic [31:0] got_data[$];
  logic [3:0]  got_be[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present the queue head as the afifo read port.
  task automatic upd();
    empty = (src.size() == 0);
    rdata = empty ? 8'h00 : src[0];
  endtask

  // One clock: record what the DUT does this cycle, then advance the source on a pop.
  task automatic tick();
    logic p;
    #1;
    p = rinc;
    if (rinc && empty) n_pop_empty++;
    if (rinc) begin
      rinc_total++;
      run_cur++;
      if (run_cur > run_max) run_max = run_cur;
    end else begin
      run_cur = 0;
    end
    if (word_valid) wv_cycles++;
    if (word_valid && word_ready) begin
      got_data.push_back(word_data);
      got_be.push_back(byte_en);
    end
    @(posedge rclk);
    if (p && src.size() > 0) src.delete(0);
    #1;
    upd();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected finish");
    $fatal(1);
  end

  initial begin
    // Reset with data waiting: nothing may be popped or presented.
    r_nrst     = 1'b0;
    empty      = 1'b0;
    rdata      = 8'h99;
    flush      = 1'b0;
    word_ready = 1'b0;
    #3;
    check("rst_rinc",  rinc, 0);
    check("rst_wv",    word_valid, 0);
    check("rst_data",  word_data, 0);
    check("rst_be",    byte_en, 0);
    check("rst_cnt",   word_cnt, 0);
    repeat (2) @(posedge rclk);
    #1;
    check("rst_be_hold", byte_en, 0);
    check("rst_wv_hold", word_valid, 0);
    @(negedge rclk);
    r_nrst = 1'b1;

    // Four back-to-back bytes make one full word presented for one cycle.
    src = '{8'h11, 8'h22, 8'h33, 8'h44};
    upd();
    word_ready = 1'b1;
    wv_cycles = 0;
    repeat (8) tick();
    check("t1_nwords", got_data.size(), 1);
    check("t1_data",   got_data[0], 32'h44332211);
    check("t1_be",     got_be[0], 4'hF);
    check("t1_wvcyc",  wv_cycles, 1);
    check("t1_cnt",    word_cnt, 1);

    // Eight continuous bytes stream without a bubble.
    got_data.delete(); got_be.delete();
    src = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    upd();
    run_cur = 0; run_max = 0; rinc_total = 0;
    repeat (12) tick();
    check("t2_nwords", got_data.size(), 2);
    check("t2_w0",     got_data[0], 32'h04030201);
    check("t2_w1",     got_data[1], 32'h08070605);
    check("t2_be1",    got_be[1], 4'hF);
    check("t2_run",    run_max, 8);
    check("t2_pops",   rinc_total, 8);
    check("t2_cnt",    word_cnt, 3);

    // Explicit flush of a two-byte partial word, then a flush with nothing buffered.
    got_data.delete(); got_be.delete();
    src = '{8'hAA, 8'hBB};
    upd();
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t3_wv",   word_valid, 1);
    check("t3_data", word_data, 32'h0000BBAA);
    check("t3_be",   byte_en, 4'h3);
    tick();
    check("t3_cnt",  word_cnt, 4);
    wv_cycles = 0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (3) tick();
    check("t3_empty_flush_wv", wv_cycles, 0);
    check("t3_empty_flush_cnt", word_cnt, 4);

    // Idle timeout turns a lone byte into a word.
    word_ready = 1'b0;
    src = '{8'h5A};
    upd();
    tick();
    repeat (15) tick();
    check("t4_not_yet", word_valid, 0);
    tick();
    check("t4_wv",   word_valid, 1);
    check("t4_data", word_data, 32'h0000005A);
    check("t4_be",   byte_en, 4'h1);
    word_ready = 1'b1;
    tick();
    check("t4_cnt",  word_cnt, 5);

    // A held word blocks popping and stays stable until accepted.
    word_ready = 1'b0;
    got_data.delete(); got_be.delete();
    src = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hD5};
    upd();
    repeat (4) tick();
    check("t5_hold_data", word_data, 32'hC4C3C2C1);
    bad_rinc = 0; bad_stab = 0;
    repeat (10) begin
      #1;
      if (rinc) bad_rinc++;
      if (word_data !== 32'hC4C3C2C1 || byte_en !== 4'hF || empty !== 1'b0) bad_stab++;
      tick();
    end
    check("t5_rinc_low", bad_rinc, 0);
    check("t5_stable",   bad_stab, 0);
    check("t5_wv",       word_valid, 1);
    word_ready = 1'b1;
    #1;
    check("t5_rinc_on_ready", rinc, 1);
    tick();
    check("t5_got",  got_data[0], 32'hC4C3C2C1);
    check("t5_be",   byte_en, 4'h1);
    check("t5_data", word_data, 32'h000000D5);
    check("t5_cnt",  word_cnt, 6);
    check("t5_wv_after", word_valid, 0);

    // Reset in the middle of a word drops it; the next four bytes form a clean word.
    src = '{8'hE1};
    upd();
    tick();
    check("t6_pre_be",   byte_en, 4'h3);
    check("t6_pre_data", word_data, 32'h0000E1D5);
    src = '{8'h31, 8'h32, 8'h33, 8'h34};
    upd();
    #2;
    r_nrst = 1'b0;
    #1;
    check("t6_rst_be",   byte_en, 0);
    check("t6_rst_data", word_data, 0);
    check("t6_rst_cnt",  word_cnt, 0);
    check("t6_rst_wv",   word_valid, 0);
    check("t6_rst_rinc", rinc, 0);
    #2;
    r_nrst = 1'b1;
    got_data.delete(); got_be.delete();
    repeat (8) tick();
    check("t6_nwords", got_data.size(), 1);
    check("t6_data",   got_data[0], 32'h34333231);
    check("t6_be",     got_be[0], 4'hF);
    check("t6_cnt",    word_cnt, 1);

    check("no_pop_when_empty", n_pop_empty, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/afifo_word_packer.md
AFIFO_WORD_PACKER -- requirements
Module: afifo_word_packer

Interface
REQ-001 The module SHALL take parameter DATA_WIDTH, default 8, meaning the width of one byte lane and of the afifo read data.
REQ-002 The module SHALL take parameter LANES, default 4, meaning the number of byte lanes per output word (range 2..8).
REQ-003 The module SHALL take parameter TIMEOUT, default 16, meaning the idle cycles after which a partial word auto-flushes (≥2).
REQ-004 The module SHALL have port rclk, input, 1 bit: the single clock, i.e. the afifo read clock.
REQ-005 The module SHALL have port r_nrst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The module SHALL have port empty, input, 1 bit: afifo read side empty.
REQ-007 The module SHALL have port rdata, input, DATA_WIDTH bits: afifo head data, valid whenever empty=0.
REQ-008 The module SHALL have port rinc, output, 1 bit: afifo pop strobe.
REQ-009 The module SHALL have port flush, input, 1 bit: emit the current partial word.
REQ-010 The module SHALL have port word_valid, output, 1 bit: output word available.
REQ-011 The module SHALL have port word_ready, input, 1 bit: the consumer accepts the word.
REQ-012 The module SHALL have port word_data, output, DATA_WIDTH*LANES bits: packed word; lane 0 is in the LSBs and holds the first byte popped.
REQ-013 The module SHALL have port byte_en, output, LANES bits: one bit per lane, set when that lane holds valid data.
REQ-014 The module SHALL have port word_cnt, output, 16 bits: count of words handed off, wrapping modulo 2^16.

Function
REQ-015 The FSM SHALL have two states, FILL and HOLD.
REQ-016 rinc SHALL be combinational: rinc = !empty & (state==FILL | (state==HOLD & word_ready)).
REQ-017 rinc SHALL never be asserted while empty=1.
REQ-018 In FILL, a pop SHALL write rdata into lane lane_cnt, set byte_en[lane_cnt], and increment lane_cnt.
REQ-019 In FILL, a pop into lane LANES-1 SHALL move the FSM to HOLD on the next edge, with byte_en all ones.
REQ-020 In FILL with flush=1 and (lane_cnt>0 or a pop in the same cycle), the FSM SHALL move to HOLD, and the same-cycle byte SHALL be included.
REQ-021 flush with lane_cnt=0 and no pop SHALL be ignored, and no zero-byte word SHALL ever be emitted.
REQ-022 word_valid SHALL equal (state==HOLD); word_data and byte_en SHALL stay stable while word_valid=1 and word_ready=0.
REQ-023 A handshake is word_valid & word_ready; on a handshake, word_cnt SHALL increment and the FSM SHALL return to FILL.
REQ-024 On a handshake with empty=0, the popped byte SHALL go to lane 0, byte_en SHALL become 0...01, and lane_cnt SHALL become 1, so there are no bubbles between words.
REQ-025 On a handshake with empty=1, byte_en SHALL clear and lane_cnt SHALL become 0.
REQ-026 Sustained throughput SHALL be one byte per cycle when empty=0 and word_ready=1.
REQ-027 idle_cnt SHALL reset to 0 on any pop, in HOLD, or when lane_cnt=0, and SHALL otherwise increment in FILL.
REQ-028 When idle_cnt reaches TIMEOUT-1, the module SHALL behave as flush=1 for that cycle.
REQ-029 No pop SHALL occur in HOLD without word_ready; backpressure SHALL propagate to the afifo, which fills and asserts its own full.
REQ-030 Lanes not flagged in byte_en SHALL read as zero.

Reset
REQ-031 While r_nrst=0 (asynchronous), the FSM SHALL be FILL, and lane_cnt, idle_cnt, word_data, byte_en and word_cnt SHALL all be 0; word_valid SHALL be 0 and rinc SHALL be 0.
REQ-032 Reset mid-word SHALL discard the partial word, with no emission after release.
REQ-033 The first pop SHALL be possible on the first rising rclk edge after r_nrst deasserts.

Verification
REQ-034 Bytes 0x11,0x22,0x33,0x44 back-to-back with word_ready=1 -> word_data=0x44332211, byte_en=4'hF, word_valid for one cycle, word_cnt=1.
REQ-035 8 bytes 0x01..0x08 continuous with word_ready=1 -> words 0x04030201 then 0x08070605, rinc high for 8 consecutive cycles.
REQ-036 Bytes 0xAA,0xBB then flush=1 -> word_data=0x0000BBAA, byte_en=4'h3; flush with no data -> no word_valid.
REQ-037 One byte 0x5A then empty held for 16 cycles -> auto-flush word 0x0000005A, byte_en=4'h1.
REQ-038 Full word with word_ready=0 for 10 cycles and empty=0 -> rinc=0 throughout and word_data stable; on word_ready=1, a pop into lane 0 and byte_en=4'h1.
REQ-039 r_nrst pulsed low after 2 bytes -> all outputs 0 immediately, and the next 4 bytes form a clean word.
